// File: rtl/program_loader.sv
// Instruction memory plus a byte-serial valid/ready loader that holds the CPU core in reset.
// Define CHECKSUM_EN to require a trailing modulo-256 checksum byte after the last word.
module program_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_value,
    output logic              cpu_rst,
    output logic              busy,
    output logic              load_done,
    output logic              load_error
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    // Wide enough for a full-depth count (LEN byte 0) and for any 8-bit count.
    localparam int unsigned CntW  = ((ADDR_W > 8) ? ADDR_W : 8) + 1;

    typedef enum logic [2:0] {StIdle, StLen, StLo, StHi, StCsum, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [CntW-1:0]   remain_q;
    logic [7:0]        lo_q;
    logic [7:0]        sum_q;
    logic              cpu_rst_q;
    logic              byte_ready_q;
    logic              busy_q;
    logic              load_done_q;
    logic [WORD_W-1:0] mem_q [Depth];
    logic              accept;

    assign accept = byte_valid && byte_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            remain_q     <= '0;
            lo_q         <= '0;
            sum_q        <= '0;
            cpu_rst_q    <= 1'b1;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load_start) begin
                        state_q      <= StLen;
                        cpu_rst_q    <= 1'b1;
                        byte_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                StLen: begin
                    if (accept) begin
                        remain_q <= (byte_in == 8'd0) ? (CntW'(1) << ADDR_W) : CntW'(byte_in);
                        wr_ptr_q <= '0;
                        sum_q    <= '0;
                        state_q  <= StLo;
                    end
                end
                StLo: begin
                    if (accept) begin
                        lo_q    <= byte_in;
                        sum_q   <= sum_q + byte_in;
                        state_q <= StHi;
                    end
                end
                StHi: begin
                    if (accept) begin
                        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                        remain_q <= remain_q - CntW'(1);
                        sum_q    <= sum_q + byte_in;
                        if (remain_q == CntW'(1)) begin
`ifdef CHECKSUM_EN
                            state_q <= StCsum;
`else
                            state_q      <= StDone;
                            byte_ready_q <= 1'b0;
                            load_done_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= StLo;
                        end
                    end
                end
`ifdef CHECKSUM_EN
                StCsum: begin
                    if (accept) begin
                        byte_ready_q <= 1'b0;
                        if (byte_in == sum_q) begin
                            state_q     <= StDone;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
`endif
                StDone: begin
                    state_q   <= StIdle;
                    cpu_rst_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q      <= StIdle;
                    byte_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

`ifdef CHECKSUM_EN
    logic load_error_q;

    // Sticky until a checksum matches or rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_error_q <= 1'b0;
        end else if (state_q == StCsum && accept) begin
            load_error_q <= (byte_in != sum_q);
        end
    end

    assign load_error = load_error_q;
`else
    assign load_error = 1'b0;
`endif

    // Memory contents survive rst_n, so a partial load stays visible.
    always_ff @(posedge clk) begin
        if (state_q == StHi && accept) begin
            mem_q[wr_ptr_q] <= WORD_W'({byte_in, lo_q});
        end
    end

    assign mem_value  = mem_q[mem_address];
    assign cpu_rst    = cpu_rst_q;
    assign byte_ready = byte_ready_q;
    assign busy       = busy_q;
    assign load_done  = load_done_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a driver streams randomised programs and queues the
// expected completion events and read-back words; a monitor compares on every negedge.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  mem_address;
    logic [15:0] mem_value;
    logic        cpu_rst;
    logic        busy;
    logic        load_done;
    logic        load_error;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_W(8),
        .WORD_W(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_address(mem_address),
        .mem_value  (mem_value),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] ref_mem [256];
    logic [15:0] stim    [256];
    int          evq[$];      // 1 = load_done pulse, 2 = load_error rising
    logic [15:0] rdq[$];
    logic [7:0]  rda[$];
    logic        rd_req = 1'b0;
    logic        err_prev = 1'b0;
    logic        rel_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: everything the DUT presents is checked against the queued expectations.
    initial begin
        int          obs;
        int          ev;
        logic [15:0] exp_w;
        logic [7:0]  exp_a;
        forever begin
            @(negedge clk);
            #1;
            if (rel_pending) begin
                chk("cpu_rst_release_after_done", 32'(cpu_rst), 32'd0);
                rel_pending = 1'b0;
            end
            if (load_done || (load_error && !err_prev)) begin
                obs = load_done ? 1 : 2;
                if (evq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", obs,
                             $time);
                end else begin
                    ev = evq.pop_front();
                    chk("completion_event_kind", obs, ev);
                end
                chk("cpu_rst_held_at_completion", 32'(cpu_rst), 32'd1);
                if (load_done) rel_pending = 1'b1;
            end
            err_prev = load_error;
            if (rd_req) begin
                exp_w = rdq.pop_front();
                exp_a = rda.pop_front();
                chk($sformatf("mem_read[%0d]", exp_a), 32'(mem_value), 32'(exp_w));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned gapmax);
        int waited = 0;
        byte_valid = 1'b0;
        repeat ($urandom_range(gapmax, 0)) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL byte_ready_timeout: got 0 expected 1 (t=%0t)", $time);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in    = $urandom();
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (busy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got busy 1 expected 0 (t=%0t)", $time);
        end
    endtask

    // Streams stim[0..n-1]; the model holds every word that reaches memory.
    task automatic run_load(input int n, input int unsigned gapmax, input bit bad,
                            input bit poke);
        logic [7:0] sum = 8'd0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        send_byte(8'(n), gapmax);
        if (poke) begin
            load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
            chk("start_in_lo_busy", 32'(busy), 32'd1);
            chk("start_in_lo_ready", 32'(byte_ready), 32'd1);
        end
        for (int i = 0; i < n; i++) begin
            send_byte(stim[i][7:0], gapmax);
            sum = sum + stim[i][7:0] + stim[i][15:8];
`ifndef CHECKSUM_EN
            if (i == n - 1) evq.push_back(bad ? 2 : 1);
`endif
            send_byte(stim[i][15:8], gapmax);
            ref_mem[i] = stim[i];
        end
`ifdef CHECKSUM_EN
        evq.push_back(bad ? 2 : 1);
        send_byte(bad ? sum + 8'd1 : sum, gapmax);
`endif
        wait_idle();
    endtask

    task automatic readback(input int n);
        for (int a = 0; a < n; a++) begin
            mem_address = 8'(a);
            rdq.push_back(ref_mem[a]);
            rda.push_back(8'(a));
            rd_req = 1'b1;
            @(negedge clk);
        end
        rd_req = 1'b0;
    endtask

    task automatic rand_stim(input int n);
        for (int i = 0; i < n; i++) stim[i] = 16'($urandom());
    endtask

    initial begin
        int n;
        int held;
        rst_n       = 1'b0;
        load_start  = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        mem_address = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_byte_ready", 32'(byte_ready), 32'd0);
        chk("reset_load_done", 32'(load_done), 32'd0);
        chk("reset_load_error", 32'(load_error), 32'd0);
        rst_n = 1'b1;

        held = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cpu_rst === 1'b1) held++;
        end
        chk("idle_cpu_rst_cycles", held, 100);

        // Reference two-word program.
        stim[0] = 16'h0501;
        stim[1] = 16'h0A02;
        run_load(2, 0, 1'b0, 1'b0);
        chk("after_load_cpu_rst", 32'(cpu_rst), 32'd0);
        mem_address = 8'd1;
        #1;
        chk("immediate_read_addr1", 32'(mem_value), 32'h0A02);
        @(negedge clk);
        readback(2);

        // Throttled random programs.
        for (int t = 0; t < 3; t++) begin
            n = int'($urandom_range(12, 1));
            rand_stim(n);
            run_load(n, 3, 1'b0, 1'b0);
            readback(n);
        end

        // Full-depth program via LEN = 0.
        for (int i = 0; i < 256; i++) stim[i] = {~8'(i), 8'(i)};
        run_load(256, 1, 1'b0, 1'b0);
        readback(256);
        stim[0] = 16'h1234;
        run_load(1, 0, 1'b0, 1'b0);
        readback(2);

        // Reset after 3 of 4 words: written words stay, the rest is untouched.
        rand_stim(4);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        send_byte(8'd4, 2);
        for (int i = 0; i < 3; i++) begin
            send_byte(stim[i][7:0], 2);
            send_byte(stim[i][15:8], 2);
            ref_mem[i] = stim[i];
        end
        rst_n = 1'b0;
        #1;
        chk("midload_reset_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("midload_reset_busy", 32'(busy), 32'd0);
        chk("midload_reset_byte_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cpu_rst", 32'(cpu_rst), 32'd1);
        readback(4);
        rand_stim(4);
        run_load(4, 2, 1'b0, 1'b0);
        chk("reload_cpu_rst", 32'(cpu_rst), 32'd0);
        readback(4);

        // load_start while in LO must not restart the load.
        rand_stim(3);
        run_load(3, 2, 1'b0, 1'b1);
        readback(3);

`ifdef CHECKSUM_EN
        stim[0] = 16'h0501;
        stim[1] = 16'h0A02;
        run_load(2, 0, 1'b1, 1'b0);
        chk("bad_csum_load_error", 32'(load_error), 32'd1);
        chk("bad_csum_cpu_rst", 32'(cpu_rst), 32'd1);
        repeat (2) @(negedge clk);
        chk("bad_csum_error_sticky", 32'(load_error), 32'd1);
        rand_stim(5);
        run_load(5, 1, 1'b0, 1'b0);
        chk("good_csum_clears_error", 32'(load_error), 32'd0);
        chk("good_csum_cpu_rst", 32'(cpu_rst), 32'd0);
        readback(5);
`else
        chk("load_error_tied_low", 32'(load_error), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("pending_events", evq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Instruction memory and byte-serial program loader that sits directly upstream of the CPU core.
- Drives the core's 16-bit mem_value from the core's 8-bit mem_address using a combinational read.
- Accepts a program over a valid/ready byte stream and writes it into the memory.
- Holds the core in reset while a load is in progress and releases it after a successful load.

Parameters:
ADDR_W, 8, memory address width; depth = 2**ADDR_W words
WORD_W, 16, instruction word width; fixed at 2 bytes per word

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  single-cycle request to begin a load; honoured only in IDLE
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader can accept a byte this cycle
mem_address  input  ADDR_W  read address from the CPU core
mem_value  output  WORD_W  instruction word at mem_address (combinational)
cpu_rst  output  1  active-high reset to the CPU core
busy  output  1  high in every state except IDLE
load_done  output  1  one-cycle pulse when a load completes successfully
load_error  output  1  sticky checksum failure flag (CHECKSUM_EN only; otherwise tied 0)

Behaviour:
- Reset (rst_n low, async) values:
  - state = IDLE, cpu_rst = 1, byte_ready = 0, busy = 0, load_done = 0, load_error = 0.
  - Write pointer = 0; memory contents are not reset.
  - cpu_rst stays 1 after reset until the first successful load.
- Handshake:
  - A byte is accepted on a posedge with byte_valid && byte_ready.
  - byte_ready = 1 exactly in LEN, LO, HI and CSUM.
  - byte_valid with byte_ready = 0 is ignored; the sender must hold the byte.
- States:
  - IDLE: load_start -> LEN; cpu_rst asserts on that same edge (registered).
  - LEN: the accepted byte is the word count N, with 0 meaning 2**ADDR_W words. Latch N, clear the write pointer and running sum, go to LO.
  - LO: latch the low byte (opcode/register fields); go to HI.
  - HI: write {byte_in, lo_latch} to mem[wr_ptr], increment wr_ptr (wraps modulo 2**ADDR_W), decrement the remaining count. If the remaining count reaches 0, go to CSUM when CHECKSUM_EN is defined, else DONE; otherwise go to LO.
  - CSUM: see Optional Feature.
  - DONE: one cycle; cpu_rst stays 1, load_done = 1, next state IDLE. cpu_rst deasserts on the DONE -> IDLE edge, so the core sees at least one reset cycle after the final write.
- Read port:
  - mem_value = mem[mem_address] combinationally, with no latency.
  - A write at edge t is visible on mem_value after edge t.
  - Reads during a load return current contents; they are don't-care because the core is held in reset.
- load_start outside IDLE is ignored. No abort exists except rst_n.
- rst_n mid-load: state returns to IDLE and cpu_rst = 1. Already-written words are kept; the memory is partially loaded and the core stays in reset until a full successful load.
- The running sum is the 8-bit modulo-256 sum of all LO and HI bytes; the LEN byte is excluded.

Optional Feature:
CHECKSUM_EN
- Defined:
  - After the last HI, the loader enters CSUM and accepts one byte.
  - Byte equals running sum: go to DONE and clear load_error.
  - Byte does not equal running sum: set load_error, go to IDLE, keep cpu_rst = 1, no load_done.
  - load_error clears on the next successful load or on rst_n.
- Not defined:
  - The CSUM state is absent and the stream ends after the last HI byte.
  - load_error is constant 0.

Test Plan:
- Reset then idle: cpu_rst = 1, busy = 0, byte_ready = 0; load_start never asserted -> cpu_rst remains 1 for 100 cycles.
- Load N = 2, bytes 01 05 / 02 0A (checksum 0x12 if enabled) -> mem[0] = 0x0501, mem[1] = 0x0A02; load_done pulses once; cpu_rst falls the cycle after DONE; mem_address = 1 gives mem_value = 0x0A02 immediately.
- Throttled stream: byte_valid toggles every other cycle with a random gap of 0–3 cycles -> identical memory image; no byte dropped or duplicated.
- N = 0 (256 words, pattern word i = {~i, i}) -> all 256 addresses written; wr_ptr wraps to 0; mem[255] = 0x00FF.
- rst_n pulsed low after 3 of 4 words -> state IDLE, cpu_rst = 1, the 3 written words retained; a new full load then succeeds.
- CHECKSUM_EN: correct checksum -> load_done; wrong checksum (0x13 instead of 0x12) -> load_error = 1, cpu_rst = 1, no load_done; load_start during LO is ignored with no state change.
